sm_divider: RTL and testbench

- Sequential 16-bit sign-magnitude fixed-point divider for the ZF detector datapath, used to form entries of the inverse channel matrix from the determinant.
- Operands use the same sign-magnitude format as the adder: bit 15 is the sign, bits 14:0 are the magnitude, and zero is always +0.
- Division is restoring: repeated magnitude compare/subtract, one quotient bit per cycle, behind a start/busy/done handshake.

---
 rtl/sm_pkg.sv | 21 ++
 rtl/sm_div_step.sv | 25 ++
 rtl/sm_divider.sv | 116 +++++++++++
 tb/tb_sm_divider.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sm_pkg.sv
// Shared sign-magnitude definitions for the adder, multiplier and divider.
// Bit 15 is the sign, bits 14:0 the magnitude; zero is always +0.
package sm_pkg;

  localparam int SM_W     = 16;
  localparam int MAG_W    = 15;
  localparam int SIGN_BIT = 15;

  localparam logic [SM_W-1:0]  SM_ZERO    = 16'h0000;
  localparam logic [MAG_W-1:0] SM_MAX_MAG = 15'h7FFF;

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t CALC = 1'b1;

  // Builds a sign-magnitude word, suppressing -0.
  function automatic logic [SM_W-1:0] sm_pack(input logic sign, input logic [MAG_W-1:0] mag);
    return {sign & (mag != '0), mag};
  endfunction

endpackage

// File: rtl/sm_div_step.sv
// One restoring-division step: shift in the next dividend bit, then
// subtract the divisor if it fits.
module sm_div_step
  import sm_pkg::*;
(
  input  logic [MAG_W-1:0] rem_in,
  input  logic             bit_in,
  input  logic [MAG_W-1:0] divisor,
  output logic [MAG_W-1:0] rem_out,
  output logic             q_bit
);

  logic [MAG_W:0] trial;
  logic [MAG_W:0] diff;

  // NOTE: every output is assigned on every path through this block, so no latch is inferred.
  always_comb begin
    trial   = {rem_in, bit_in};
    diff    = trial - {1'b0, divisor};
    q_bit   = (trial >= {1'b0, divisor});
    // The remainder stays below the divisor, so it always fits in MAG_W bits.
    rem_out = q_bit ? diff[MAG_W-1:0] : trial[MAG_W-1:0];
  end

endmodule

// File: rtl/sm_divider.sv
// Sequential sign-magnitude fixed-point divider (restoring, one quotient
// bit per cycle) with a start/busy/done handshake.
module sm_divider
  import sm_pkg::*;
#(
  parameter int FRAC = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] n,
  input  logic [15:0] d,
  output logic        busy,
  output logic        done,
  output logic [15:0] q,
  output logic        ovf,
  output logic        dbz
);

  localparam int ITER  = MAG_W + FRAC;
  localparam int CNT_W = $clog2(ITER);

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [ITER-1:0]    dvd_r;
  logic [MAG_W-1:0]   dvs_r;
  logic [MAG_W-1:0]   rem_r;
  logic [ITER-1:0]    quo_r;
  logic               sign_r;
  logic [SM_W-1:0]    q_r;
  logic               ovf_r;
  logic               dbz_r;
  logic               done_r;

  logic [MAG_W-1:0]   rem_nx;
  logic               q_bit;
  logic [ITER-1:0]    raw_nx;
  logic               sat_nx;
  logic [MAG_W-1:0]   mag_nx;

  sm_div_step u_step (
    .rem_in  (rem_r),
    .bit_in  (dvd_r[ITER-1]),
    .divisor (dvs_r),
    .rem_out (rem_nx),
    .q_bit   (q_bit)
  );

  // Quotient including this cycle's bit; only used on the final iteration.
  always_comb begin
    raw_nx = {quo_r[ITER-2:0], q_bit};
    sat_nx = (raw_nx > ITER'(SM_MAX_MAG));
    mag_nx = sat_nx ? SM_MAX_MAG : raw_nx[MAG_W-1:0];
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: all registers, datapath included, are cleared so a reset mid-divide leaves no stale state.
      state  <= IDLE;
      count  <= '0;
      dvd_r  <= '0;
      dvs_r  <= '0;
      rem_r  <= '0;
      quo_r  <= '0;
      sign_r <= 1'b0;
      q_r    <= SM_ZERO;
      ovf_r  <= 1'b0;
      dbz_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (d[MAG_W-1:0] == '0) begin
              q_r    <= {1'b0, SM_MAX_MAG};
              ovf_r  <= 1'b0;
              dbz_r  <= 1'b1;
              done_r <= 1'b1;
            end else begin
              dvd_r  <= ITER'(n[MAG_W-1:0]) << FRAC;
              dvs_r  <= d[MAG_W-1:0];
              sign_r <= n[SIGN_BIT] ^ d[SIGN_BIT];
              rem_r  <= '0;
              quo_r  <= '0;
              count  <= '0;
              state  <= CALC;
            end
          end
        end
        CALC: begin
          rem_r <= rem_nx;
          dvd_r <= dvd_r << 1;
          quo_r <= raw_nx;
          count <= count + CNT_W'(1);
          if (count == CNT_W'(ITER - 1)) begin
            state  <= IDLE;
            q_r    <= sm_pack(sign_r, mag_nx);
            ovf_r  <= sat_nx;
            dbz_r  <= 1'b0;
            done_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == CALC);
  assign done = done_r;
  assign q    = q_r;
  assign ovf  = ovf_r;
  assign dbz  = dbz_r;

endmodule

// File: tb/tb_sm_divider.sv
// Directed self-checking bench for sm_divider with FRAC=8 (23-cycle divides).
module tb_sm_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] n;
  logic [15:0] d;
  logic        busy;
  logic        done;
  logic [15:0] q;
  logic        ovf;
  logic        dbz;

  int checks = 0;
  int errors = 0;

  sm_divider #(.FRAC(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .n     (n),
    .d     (d),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .ovf   (ovf),
    .dbz   (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one divide and waits (bounded) for done; returns in the done cycle.
  // With b2b set, start is raised in the current (done) cycle without waiting.
  task automatic run_div(input string tag, input logic [15:0] nv, input logic [15:0] dv,
                         input bit b2b, input logic [15:0] eq, input logic eovf,
                         input logic edbz, input int elat);
    int lat  = 0;
    int bcnt = 0;
    if (!b2b) @(negedge clk);
    n = nv;
    d = dv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 16'h0000;
    d = 16'h0000;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      lat++;
      @(negedge clk);
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_latency"}, lat, elat);
    check({tag, "_busy_cycles"}, bcnt, elat);
    check({tag, "_busy_in_done"}, busy, 0);
    check({tag, "_q"}, q, eq);
    check({tag, "_ovf"}, ovf, eovf);
    check({tag, "_dbz"}, dbz, edbz);
  endtask

  initial begin
    int done_cnt;
    int busy_cnt;
    logic [15:0] q_cap;
    logic        dbz_cap;

    rst = 1'b1;
    start = 1'b0;
    n = 16'h0000;
    d = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", q, 16'h0000);
    check("rst_ovf", ovf, 0);
    check("rst_dbz", dbz, 0);
    rst = 1'b0;

    // +1.5 / +0.5 = +3.0
    run_div("pos_div", 16'h0180, 16'h0080, 1'b0, 16'h0300, 1'b0, 1'b0, 23);
    @(negedge clk);
    check("pos_div_pulse", done, 0);
    check("pos_div_hold", q, 16'h0300);

    // -1.0 / +0.25 = -4.0, then -1.0 / -0.25 = +4.0 started in the done cycle
    run_div("neg_div", 16'h8100, 16'h0040, 1'b0, 16'h8400, 1'b0, 1'b0, 23);
    run_div("b2b_div", 16'h8100, 16'h8040, 1'b1, 16'h0400, 1'b0, 1'b0, 23);
    @(negedge clk);
    check("b2b_pulse", done, 0);

    // Quotient far above the format range saturates
    run_div("ovf_div", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b0, 23);

    // Reset in cycle 10 of a divide aborts it without a done
    @(negedge clk);
    n = 16'h0180;
    d = 16'h0080;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_q", q, 16'h0000);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_done", done, 0);
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    check("mid_rst_no_done", done_cnt, 0);
    check("mid_rst_no_busy", busy_cnt, 0);

    // +2.0 / -1.0 = -2.0 after the abort
    run_div("post_rst", 16'h0200, 16'h8100, 1'b0, 16'h8200, 1'b0, 1'b0, 23);

    // 1.0 / (3/256) = 85.33 -> 0x5555 truncated; 1.0 / 3.0 = 0.333 -> 0x0055 truncated
    run_div("trunc_small_d", 16'h0100, 16'h0003, 1'b0, 16'h5555, 1'b0, 1'b0, 23);
    run_div("trunc_third", 16'h0100, 16'h0300, 1'b0, 16'h0055, 1'b0, 1'b0, 23);

    // Divide by negative zero: immediate done, never busy
    run_div("dbz", 16'h8100, 16'h8000, 1'b0, 16'h7FFF, 1'b0, 1'b1, 0);
    @(negedge clk);
    check("dbz_pulse", done, 0);
    check("dbz_hold", dbz, 1);

    // -0 / +1.0 gives +0; a start during busy is ignored
    @(negedge clk);
    n = 16'h8000;
    d = 16'h0100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    n = 16'h0180;
    d = 16'h0080;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 16'h0000;
    d = 16'h0000;
    done_cnt = 0;
    q_cap = 16'hDEAD;
    dbz_cap = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          q_cap = q;
          dbz_cap = dbz;
        end
      end
      @(negedge clk);
    end
    check("busy_start_one_done", done_cnt, 1);
    check("neg_zero_q", q_cap, 16'h0000);
    check("neg_zero_dbz", dbz_cap, 0);
    check("idle_after", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
